// File: rtl/decode_share_arbiter.sv
// Round-robin arbiter that time-shares one 3-bit pattern decoder among N_REQ requesters.
// A winning code is decoded and returned one cycle later, tagged with its requester id.
module decode_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic               _clock,
    input  logic               _reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] code_in,
    output logic [N_REQ-1:0]   grant,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [2:0]         rsp_c,
    output logic               rsp_d,
    output logic               busy
);

    localparam int unsigned CODE_W = 3;

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_nxt;
    logic [N_REQ-1:0]  req_rot;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic              issue;
    logic [CODE_W-1:0] win_code;
    logic [2:0]        dec_c;
    logic              dec_d;
    logic              valid_nxt;
    logic [ID_W-1:0]   id_nxt;
    logic [2:0]        c_nxt;
    logic              d_nxt;

    // Priority decode of one 3-bit pattern; only 10x produces the (3,1) result.
    function automatic logic [3:0] decode(input logic [CODE_W-1:0] code);
        logic [3:0] res;
        res = {3'b010, 1'b0};
        casez (code)
            3'b10?:  res = {3'd3, 1'b1};
            3'b0?1:  res = {3'b010, 1'b0};
            default: res = {3'b010, 1'b0};
        endcase
        return res;
    endfunction

    // Rotate the request vector so that bit 0 is the current highest-priority requester.
    always_comb begin
        req_rot = N_REQ'({req, req} >> ptr_q);
    end

    // First set bit of the rotated vector, mapped back to an absolute requester index.
    always_comb begin : select_winner
        int unsigned sum;
        found  = 1'b0;
        winner = '0;
        sum    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = 32'(ptr_q) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            if (!found && req_rot[k]) begin
                found  = 1'b1;
                winner = ID_W'(sum);
            end
        end
    end

    // Route the winner's code to the shared decoder.
    always_comb begin
        win_code = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_code = code_in[CODE_W*i +: CODE_W];
            end
        end
        {dec_c, dec_d} = decode(win_code);
    end

    // A new grant is allowed only when the response slot is empty or being drained.
    always_comb begin
        issue = found && !_reset && (!rsp_valid || rsp_ready);
        grant = issue ? (N_REQ'(1) << winner) : '0;
        busy  = rsp_valid || (|req);
    end

    // Next-state for the pointer and the response slot.
    always_comb begin
        ptr_nxt   = ptr_q;
        valid_nxt = rsp_valid;
        id_nxt    = rsp_id;
        c_nxt     = rsp_c;
        d_nxt     = rsp_d;
        if (issue) begin
            valid_nxt = 1'b1;
            id_nxt    = winner;
            c_nxt     = dec_c;
            d_nxt     = dec_d;
            ptr_nxt   = (32'(winner) == N_REQ - 1) ? '0 : winner + ID_W'(1);
        end else if (rsp_valid && rsp_ready) begin
            valid_nxt = 1'b0;
        end
    end

    // Reset drops any pending response rather than delivering it.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            ptr_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
            rsp_d     <= 1'b0;
        end else begin
            ptr_q     <= ptr_nxt;
            rsp_valid <= valid_nxt;
            rsp_id    <= id_nxt;
            rsp_c     <= c_nxt;
            rsp_d     <= d_nxt;
        end
    end

endmodule

// File: tb/tb_decode_share_arbiter.sv
// Directed plus randomized bench for decode_share_arbiter against a cycle-level
// behavioural model of the arbitration and decode rules.
module tb_decode_share_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    logic               _clock;
    logic               _reset;
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] code_in;
    logic [N_REQ-1:0]   grant;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [2:0]         rsp_c;
    logic               rsp_d;
    logic               busy;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_ptr   = 0;
    int m_valid = 0;
    int m_id    = 0;
    int m_c     = 0;
    int m_d     = 0;

    decode_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        ._clock   (_clock),
        ._reset   (_reset),
        .req      (req),
        .code_in  (code_in),
        .grant    (grant),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_c    (rsp_c),
        .rsp_d    (rsp_d),
        .busy     (busy)
    );

    initial _clock = 1'b0;
    always #5 _clock = ~_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int code_of(input logic [3*N_REQ-1:0] codes, input int idx);
        logic [3*N_REQ-1:0] v;
        v = codes >> (3 * idx);
        return int'(v[2:0]);
    endfunction

    // Result value from the decode table: patterns 100 and 101 give (3,1), all others (2,0).
    function automatic int model_c(input int code);
        return (code / 4 == 1 && (code / 2) % 2 == 0) ? 3 : 2;
    endfunction

    function automatic int model_d(input int code);
        return (code / 4 == 1 && (code / 2) % 2 == 0) ? 1 : 0;
    endfunction

    // Model winner: search from the pointer with wrap; -1 when no grant this cycle.
    function automatic int model_winner(input logic [N_REQ-1:0] r, input logic rst,
                                        input logic rdy);
        if (rst || r == '0 || (m_valid != 0 && !rdy)) return -1;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (r[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    // One cycle: drive, check combinational outputs, clock, update model, check registered outputs.
    task automatic step(input logic [N_REQ-1:0] r, input logic [3*N_REQ-1:0] codes,
                        input logic rdy, input logic rst);
        int w;
        logic [N_REQ-1:0] exp_grant;
        @(negedge _clock);
        req       = r;
        code_in   = codes;
        rsp_ready = rdy;
        _reset    = rst;
        #1;
        w = model_winner(r, rst, rdy);
        exp_grant = (w < 0) ? '0 : N_REQ'(1) << w;
        check("grant", 32'(grant), 32'(exp_grant));
        check("busy", 32'(busy), 32'((m_valid != 0) || (r != '0)));
        @(posedge _clock);
        if (rst) begin
            m_valid = 0; m_id = 0; m_c = 0; m_d = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_valid = 1;
            m_id    = w;
            m_c     = model_c(code_of(codes, w));
            m_d     = model_d(code_of(codes, w));
            m_ptr   = (w + 1) % N_REQ;
        end else if (m_valid != 0 && rdy) begin
            m_valid = 0;
        end
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_c", 32'(rsp_c), 32'(m_c));
        check("rsp_d", 32'(rsp_d), 32'(m_d));
    endtask

    initial begin
        logic [3*N_REQ-1:0] codes;
        logic [N_REQ-1:0]   r;
        req       = '0;
        code_in   = '0;
        rsp_ready = 1'b1;
        _reset    = 1'b1;

        // Reset held two cycles with all requests up: nothing granted.
        step(4'b1111, 12'h000, 1'b1, 1'b1);
        step(4'b1111, 12'h000, 1'b1, 1'b1);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_c", 32'(rsp_c), 32'd0);
        step(4'b0001, 12'h000, 1'b1, 1'b0);
        check("first_grant_id", 32'(rsp_id), 32'd0);

        // Decode sweep through requester 0, including the explicit table values.
        for (int c = 0; c < 8; c++) begin
            codes = 12'(c);
            step(4'b0001, codes, 1'b1, 1'b0);
            check("tbl_c", 32'(rsp_c), (c == 4 || c == 5) ? 32'd3 : 32'd2);
            check("tbl_d", 32'(rsp_d), (c == 4 || c == 5) ? 32'd1 : 32'd0);
        end

        // Round-robin rotation with all requesters active.
        step(4'b0000, 12'h000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 12'h4c5, 1'b1, 1'b0);
            check("rr_id", 32'(rsp_id), 32'(i % 4));
        end

        // Back-pressure: result for id 2 stalls; ready return issues requester 3 at once.
        step(4'b0000, 12'h000, 1'b1, 1'b1);
        step(4'b0100, 12'h400, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1011, 12'h925, 1'b0, 1'b0);
            check("stall_id", 32'(rsp_id), 32'd2);
        end
        step(4'b1011, 12'h925, 1'b1, 1'b0);
        check("resume_valid", 32'(rsp_valid), 32'd1);
        check("resume_id", 32'(rsp_id), 32'd3);

        // Pointer at 3, requesters 0 and 2: wrap to 0, then skip to 2.
        step(4'b0000, 12'h000, 1'b1, 1'b1);
        step(4'b0100, 12'h000, 1'b1, 1'b0);
        step(4'b0101, 12'h104, 1'b1, 1'b0);
        check("wrap_id", 32'(rsp_id), 32'd0);
        step(4'b0100, 12'h104, 1'b1, 1'b0);
        check("skip_id", 32'(rsp_id), 32'd2);

        // Reset while a result is stalled: it is dropped and the pointer returns to 0.
        step(4'b1000, 12'h800, 1'b1, 1'b0);
        step(4'b0000, 12'h000, 1'b0, 1'b0);
        step(4'b0000, 12'h000, 1'b0, 1'b1);
        check("rst_drop", 32'(rsp_valid), 32'd0);
        step(4'b0110, 12'h0a0, 1'b1, 1'b0);
        check("post_rst_id", 32'(rsp_id), 32'd1);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 400; i++) begin
            r     = N_REQ'($urandom_range(0, 15));
            codes = 12'($urandom);
            step(r, codes, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
